mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter.sv | 206 ++++++++++++++++++++
 tb/tb_mem_arbiter.sv | 356 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_arbiter
// Brief    : Two-master (fetch / data) arbiter onto a single request/ack
//            memory port. Data has priority, with a starvation limit that
//            forces a fetch grant, plus a BUSY watchdog that aborts
//            transactions the memory never acknowledges.
// Revision : 1.0 - initial release
// ============================================================================
module mem_arbiter #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int STARVE_MAX = 4,
    parameter int TIMEOUT    = 255
) (
    input  logic              clk,
    input  logic              rst,

    // Fetch port (read only)
    input  logic              if_req_i,
    input  logic [ADDR_W-1:0] if_addr_i,
    output logic [DATA_W-1:0] if_rdata_o,
    output logic              if_ack_o,

    // Data port (load / store)
    input  logic              d_req_i,
    input  logic              d_we_i,
    input  logic [ADDR_W-1:0] d_addr_i,
    input  logic [DATA_W-1:0] d_wdata_i,
    output logic [DATA_W-1:0] d_rdata_o,
    output logic              d_ack_o,

    // Memory port
    output logic              mem_req_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    input  logic [DATA_W-1:0] mem_rdata_i,
    input  logic              mem_ack_i,

    // Status
    output logic              err_o,
    output logic              hold_if_o
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    // Starvation counter only ever needs to reach STARVE_MAX.
    localparam int c_SCNT_W = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
    // Watchdog counter holds 0 .. TIMEOUT-1 (one value per BUSY cycle).
    localparam int c_TCNT_W = (TIMEOUT <= 1) ? 1 : $clog2(TIMEOUT);

    localparam logic [c_SCNT_W-1:0] c_STARVE_MAX = c_SCNT_W'(STARVE_MAX);
    localparam logic [c_TCNT_W-1:0] c_TCNT_LAST  = c_TCNT_W'(TIMEOUT - 1);

    localparam logic c_OWN_IF = 1'b0;
    localparam logic c_OWN_D  = 1'b1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_RESP = 2'd2
    } state_t;

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    state_t              r_state;
    logic                r_own;
    logic [c_SCNT_W-1:0] r_starve_cnt;
    logic [c_TCNT_W-1:0] r_tcnt;

    // ------------------------------------------------------------------------
    // Combinational decode
    // ------------------------------------------------------------------------
    logic w_any_req;
    logic w_grant_d;
    logic w_timeout;

    // Data wins unless fetch has already waited through STARVE_MAX data grants.
    assign w_any_req = if_req_i | d_req_i;
    assign w_grant_d = d_req_i & ~((r_starve_cnt == c_STARVE_MAX) & if_req_i);

    // Last BUSY cycle the watchdog allows before aborting.
    assign w_timeout = (r_tcnt == c_TCNT_LAST);

    // Fetch stall: requester waiting and not being acknowledged this cycle.
    assign hold_if_o = if_req_i & ~if_ack_o;

    // ------------------------------------------------------------------------
    // Main FSM: grant in IDLE, wait for memory in BUSY, one-cycle ack in RESP
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_own       <= c_OWN_IF;
            if_ack_o    <= 1'b0;
            d_ack_o     <= 1'b0;
            err_o       <= 1'b0;
            mem_req_o   <= 1'b0;
            mem_we_o    <= 1'b0;
            mem_addr_o  <= '0;
            mem_wdata_o <= '0;
            if_rdata_o  <= '0;
            d_rdata_o   <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if_ack_o <= 1'b0;
                    d_ack_o  <= 1'b0;
                    err_o    <= 1'b0;
                    if (w_any_req) begin
                        // Command fields are latched here and stay frozen
                        // for the whole BUSY phase.
                        r_own       <= w_grant_d ? c_OWN_D : c_OWN_IF;
                        mem_we_o    <= w_grant_d & d_we_i;
                        mem_addr_o  <= w_grant_d ? d_addr_i : if_addr_i;
                        mem_wdata_o <= w_grant_d ? d_wdata_i : '0;
                        mem_req_o   <= 1'b1;
                        r_state     <= S_BUSY;
                    end
                end

                S_BUSY: begin
                    if (mem_ack_i) begin
                        // Normal completion; also wins over a same-cycle timeout.
                        mem_req_o <= 1'b0;
                        r_state   <= S_RESP;
                        if (r_own == c_OWN_D) begin
                            d_ack_o <= 1'b1;
                            if (!mem_we_o) begin
                                d_rdata_o <= mem_rdata_i;
                            end
                        end else begin
                            if_ack_o   <= 1'b1;
                            if_rdata_o <= mem_rdata_i;
                        end
                    end else if (w_timeout) begin
                        // Memory never answered: complete with zero data and flag it.
                        mem_req_o <= 1'b0;
                        err_o     <= 1'b1;
                        r_state   <= S_RESP;
                        if (r_own == c_OWN_D) begin
                            d_ack_o <= 1'b1;
                            if (!mem_we_o) begin
                                d_rdata_o <= '0;
                            end
                        end else begin
                            if_ack_o   <= 1'b1;
                            if_rdata_o <= '0;
                        end
                    end
                end

                S_RESP: begin
                    if_ack_o <= 1'b0;
                    d_ack_o  <= 1'b0;
                    err_o    <= 1'b0;
                    r_state  <= S_IDLE;
                end

                default: begin
                    if_ack_o  <= 1'b0;
                    d_ack_o   <= 1'b0;
                    err_o     <= 1'b0;
                    mem_req_o <= 1'b0;
                    r_state   <= S_IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Starvation counter: counts data grants made while fetch was waiting
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_starve_cnt <= '0;
        end else if ((r_state == S_IDLE) && w_any_req) begin
            if (w_grant_d && if_req_i) begin
                if (r_starve_cnt != c_STARVE_MAX) begin
                    r_starve_cnt <= r_starve_cnt + c_SCNT_W'(1);
                end
            end else begin
                // Fetch grant, or data grant with nobody waiting.
                r_starve_cnt <= '0;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Watchdog: counts BUSY cycles, restarts at every new transaction
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_tcnt <= '0;
        end else if (r_state != S_BUSY) begin
            r_tcnt <= '0;
        end else if (!mem_ack_i && !w_timeout) begin
            r_tcnt <= r_tcnt + c_TCNT_W'(1);
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_arbiter
// Brief    : Self-checking bench for mem_arbiter: vector table of single
//            transactions plus directed starvation, dropped-request and
//            mid-transaction reset sequences.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_arbiter;

    logic        clk;
    logic        rst;
    logic        if_req_i;
    logic [31:0] if_addr_i;
    logic [31:0] if_rdata_o;
    logic        if_ack_o;
    logic        d_req_i;
    logic        d_we_i;
    logic [31:0] d_addr_i;
    logic [31:0] d_wdata_i;
    logic [31:0] d_rdata_o;
    logic        d_ack_o;
    logic        mem_req_o;
    logic        mem_we_o;
    logic [31:0] mem_addr_o;
    logic [31:0] mem_wdata_o;
    logic [31:0] mem_rdata_i;
    logic        mem_ack_i;
    logic        err_o;
    logic        hold_if_o;

    int n_checks = 0;
    int n_errors = 0;

    mem_arbiter #(
        .ADDR_W     (32),
        .DATA_W     (32),
        .STARVE_MAX (4),
        .TIMEOUT    (255)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .if_req_i    (if_req_i),
        .if_addr_i   (if_addr_i),
        .if_rdata_o  (if_rdata_o),
        .if_ack_o    (if_ack_o),
        .d_req_i     (d_req_i),
        .d_we_i      (d_we_i),
        .d_addr_i    (d_addr_i),
        .d_wdata_i   (d_wdata_i),
        .d_rdata_o   (d_rdata_o),
        .d_ack_o     (d_ack_o),
        .mem_req_o   (mem_req_o),
        .mem_we_o    (mem_we_o),
        .mem_addr_o  (mem_addr_o),
        .mem_wdata_o (mem_wdata_o),
        .mem_rdata_i (mem_rdata_i),
        .mem_ack_i   (mem_ack_i),
        .err_o       (err_o),
        .hold_if_o   (hold_if_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory model: acknowledges after mem_lat extra cycles of mem_req_o.
    bit          mem_en    = 1'b1;
    int          mem_lat   = 0;
    int          wait_cnt  = 0;
    bit          force_ack = 1'b0;
    logic [31:0] rd_fixed  = 32'h0;
    logic        model_ack;

    // Memory responses change on the falling edge, away from DUT sampling.
    always @(negedge clk) begin
        model_ack = 1'b0;
        if (mem_req_o && mem_en) begin
            if (wait_cnt >= mem_lat) begin
                model_ack = 1'b1;
                wait_cnt  = 0;
            end else begin
                wait_cnt++;
            end
        end else begin
            wait_cnt = 0;
        end
        mem_ack_i   = model_ack | force_ack;
        mem_rdata_i = rd_fixed;
    end

    typedef struct {
        bit          d;
        bit          we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] mdata;
        int          lat;
        bit          men;
        int          exp_lat;
        bit          exp_we;
        logic [31:0] exp_if_rdata;
        logic [31:0] exp_d_rdata;
        bit          exp_err;
    } vec_t;

    vec_t vecs [8];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_ctl"}, {59'd0, if_ack_o, d_ack_o, err_o, mem_req_o, mem_we_o}, 64'd0);
        check({tag, "_mem_addr"},  {32'd0, mem_addr_o},  64'd0);
        check({tag, "_mem_wdata"}, {32'd0, mem_wdata_o}, 64'd0);
        check({tag, "_if_rdata"},  {32'd0, if_rdata_o},  64'd0);
        check({tag, "_d_rdata"},   {32'd0, d_rdata_o},   64'd0);
    endtask

    // One complete transaction on one port; called at posedge+1.
    task automatic run_txn(input vec_t v, input string tag);
        int          cyc       = 0;
        bit          got       = 1'b0;
        bit          other_ok  = 1'b1;
        bit          stable_ok = 1'b1;
        bit          hold_ok   = 1'b1;
        bit          first_req = 1'b0;
        bit          cap_we    = 1'b0;
        logic [31:0] cap_addr  = 32'h0;
        logic [31:0] cap_wdata = 32'h0;
        bit          seen_cmd  = 1'b0;
        bit          ack_err   = 1'b0;
        bit          ack_mreq  = 1'b0;
        bit          ack_hold  = 1'b0;

        rd_fixed = v.mdata;
        mem_lat  = v.lat;
        mem_en   = v.men;
        if (v.d) begin
            d_req_i   = 1'b1;
            d_we_i    = v.we;
            d_addr_i  = v.addr;
            d_wdata_i = v.wdata;
        end else begin
            if_req_i  = 1'b1;
            if_addr_i = v.addr;
            d_we_i    = 1'b1;   // stray store enable must not leak into a fetch
        end

        while (!got && cyc < 400) begin
            @(posedge clk);
            #1;
            cyc++;
            if (cyc == 1) first_req = mem_req_o;
            if (mem_req_o) begin
                if (!seen_cmd) begin
                    seen_cmd  = 1'b1;
                    cap_we    = mem_we_o;
                    cap_addr  = mem_addr_o;
                    cap_wdata = mem_wdata_o;
                end else if (mem_we_o !== cap_we || mem_addr_o !== cap_addr ||
                             mem_wdata_o !== cap_wdata) begin
                    stable_ok = 1'b0;
                end
            end
            if ((v.d ? if_ack_o : d_ack_o) !== 1'b0) other_ok = 1'b0;
            if (v.d ? d_ack_o : if_ack_o) begin
                got      = 1'b1;
                ack_err  = err_o;
                ack_mreq = mem_req_o;
                ack_hold = hold_if_o;
            end else if (!v.d && hold_if_o !== 1'b1) begin
                hold_ok = 1'b0;
            end
        end

        check({tag, "_ack_seen"},  got, 1);
        check({tag, "_latency"},   cyc, v.exp_lat);
        check({tag, "_first_req"}, first_req, 1);
        check({tag, "_mem_we"},    cap_we, v.exp_we);
        check({tag, "_mem_addr"},  cap_addr, v.addr);
        if (v.d) check({tag, "_mem_wdata"}, cap_wdata, v.wdata);
        check({tag, "_cmd_stable"}, stable_ok, 1);
        check({tag, "_other_ack"},  other_ok, 1);
        check({tag, "_err"},        ack_err, v.exp_err);
        check({tag, "_req_drop"},   ack_mreq, 0);
        check({tag, "_if_rdata"},   if_rdata_o, v.exp_if_rdata);
        check({tag, "_d_rdata"},    d_rdata_o, v.exp_d_rdata);
        if (!v.d) begin
            check({tag, "_hold_wait"}, hold_ok, 1);
            check({tag, "_hold_ack"},  ack_hold, 0);
        end

        if_req_i = 1'b0;
        d_req_i  = 1'b0;
        d_we_i   = 1'b0;
        @(posedge clk);
        #1;
        check({tag, "_ack_pulse"}, {if_ack_o, d_ack_o, err_o}, 3'b000);
        mem_en = 1'b1;
    endtask

    initial begin
        vec_t        v_post;
        logic [9:0]  got_pat;
        int          n_acks;
        int          cyc;
        bit          both_ok;
        int          acks;
        int          rises;
        logic        prev_req;
        bit          quiet_ok;

        //          IF fetch 0x100, memory answers after 3 extra cycles
        vecs[0] = '{d:1'b0, we:1'b0, addr:32'h100, wdata:32'h0, mdata:32'hDEADBEEF, lat:3, men:1'b1,
                    exp_lat:5, exp_we:1'b0, exp_if_rdata:32'hDEADBEEF, exp_d_rdata:32'h0, exp_err:1'b0};
        vecs[1] = '{d:1'b1, we:1'b0, addr:32'h40, wdata:32'h0, mdata:32'h12345678, lat:0, men:1'b1,
                    exp_lat:2, exp_we:1'b0, exp_if_rdata:32'hDEADBEEF, exp_d_rdata:32'h12345678, exp_err:1'b0};
        //          store: d_rdata_o must keep the previous load value
        vecs[2] = '{d:1'b1, we:1'b1, addr:32'h20, wdata:32'h55, mdata:32'hFFFFFFFF, lat:2, men:1'b1,
                    exp_lat:4, exp_we:1'b1, exp_if_rdata:32'hDEADBEEF, exp_d_rdata:32'h12345678, exp_err:1'b0};
        vecs[3] = '{d:1'b0, we:1'b0, addr:32'h104, wdata:32'h0, mdata:32'hCAFEF00D, lat:1, men:1'b1,
                    exp_lat:3, exp_we:1'b0, exp_if_rdata:32'hCAFEF00D, exp_d_rdata:32'h12345678, exp_err:1'b0};
        //          memory silent: 255 BUSY cycles, then ack + err with zero data
        vecs[4] = '{d:1'b0, we:1'b0, addr:32'h200, wdata:32'h0, mdata:32'h11111111, lat:0, men:1'b0,
                    exp_lat:256, exp_we:1'b0, exp_if_rdata:32'h0, exp_d_rdata:32'h12345678, exp_err:1'b1};
        vecs[5] = '{d:1'b1, we:1'b0, addr:32'h48, wdata:32'h0, mdata:32'h0BADC0DE, lat:4, men:1'b1,
                    exp_lat:6, exp_we:1'b0, exp_if_rdata:32'h0, exp_d_rdata:32'h0BADC0DE, exp_err:1'b0};
        //          ack lands in the 255th BUSY cycle: normal completion wins
        vecs[6] = '{d:1'b1, we:1'b0, addr:32'h4C, wdata:32'h0, mdata:32'h87654321, lat:254, men:1'b1,
                    exp_lat:256, exp_we:1'b0, exp_if_rdata:32'h0, exp_d_rdata:32'h87654321, exp_err:1'b0};
        vecs[7] = '{d:1'b0, we:1'b0, addr:32'h108, wdata:32'h0, mdata:32'hA5A5A5A5, lat:0, men:1'b1,
                    exp_lat:2, exp_we:1'b0, exp_if_rdata:32'hA5A5A5A5, exp_d_rdata:32'h87654321, exp_err:1'b0};

        rst       = 1'b1;
        if_req_i  = 1'b0;
        if_addr_i = 32'h0;
        d_req_i   = 1'b0;
        d_we_i    = 1'b0;
        d_addr_i  = 32'h0;
        d_wdata_i = 32'h0;
        repeat (3) @(posedge clk);
        #1;
        check_all_zero("reset");
        check("reset_hold_if", hold_if_o, 0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        for (int i = 0; i < 8; i++) begin
            run_txn(vecs[i], $sformatf("v%0d", i));
        end

        // Both masters requesting continuously: fetch gets every 5th grant.
        d_we_i    = 1'b0;
        d_addr_i  = 32'h300;
        if_addr_i = 32'h400;
        rd_fixed  = 32'h0000_1234;
        mem_lat   = 0;
        if_req_i  = 1'b1;
        d_req_i   = 1'b1;
        got_pat   = '0;
        n_acks    = 0;
        cyc       = 0;
        both_ok   = 1'b1;
        while (n_acks < 10 && cyc < 200) begin
            @(posedge clk);
            #1;
            cyc++;
            if (d_ack_o && if_ack_o) both_ok = 1'b0;
            if (d_ack_o || if_ack_o) begin
                got_pat[9 - n_acks] = d_ack_o;
                n_acks++;
            end
        end
        if_req_i = 1'b0;
        d_req_i  = 1'b0;
        check("starve_n_acks", n_acks, 10);
        check("starve_pattern", got_pat, 10'b1111011110);
        check("starve_single_ack", both_ok, 1);
        repeat (3) @(posedge clk);
        #1;
        check("starve_quiet", mem_req_o, 0);

        // Data request dropped after the grant still completes exactly once.
        d_we_i   = 1'b0;
        d_addr_i = 32'h60;
        rd_fixed = 32'h600DF00D;
        mem_lat  = 3;
        prev_req = mem_req_o;
        d_req_i  = 1'b1;
        acks     = 0;
        rises    = 0;
        @(posedge clk);
        #1;
        d_req_i = 1'b0;
        if (mem_req_o && !prev_req) rises++;
        prev_req = mem_req_o;
        for (int k = 0; k < 20; k++) begin
            @(posedge clk);
            #1;
            if (mem_req_o && !prev_req) rises++;
            prev_req = mem_req_o;
            if (d_ack_o) acks++;
        end
        check("drop_acks", acks, 1);
        check("drop_grants", rises, 1);
        check("drop_d_rdata", d_rdata_o, 32'h600DF00D);

        // Reset in the middle of BUSY, then a late memory ack.
        d_we_i    = 1'b1;
        d_addr_i  = 32'h80;
        d_wdata_i = 32'h99;
        rd_fixed  = 32'h77777777;
        mem_lat   = 6;
        d_req_i   = 1'b1;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        check("rst_busy_req", mem_req_o, 1);
        rst     = 1'b1;
        d_req_i = 1'b0;
        d_we_i  = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check_all_zero("rst_mid");
        force_ack = 1'b1;
        quiet_ok  = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk);
            #1;
            if (if_ack_o || d_ack_o || err_o || mem_req_o) quiet_ok = 1'b0;
        end
        force_ack = 1'b0;
        check("rst_late_ack_ignored", quiet_ok, 1);
        check_all_zero("rst_after");

        // Normal operation after reset.
        v_post = '{d:1'b0, we:1'b0, addr:32'h500, wdata:32'h0, mdata:32'h13579BDF, lat:1, men:1'b1,
                   exp_lat:3, exp_we:1'b0, exp_if_rdata:32'h13579BDF, exp_d_rdata:32'h0, exp_err:1'b0};
        @(posedge clk);
        #1;
        run_txn(v_post, "post_rst");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
